multicycle_ctrl: RTL and testbench

Multi-cycle control sequencer for the RV32I core subset (lw, sw, R-type ALU, I-type ALU, beq, jal). It drives a shared-ALU, single-memory datapath through fetch/decode/execute/memory/writeback states. It handshakes with a variable-latency memory and keeps a retired-instruction counter. It replaces the purely combinational decode of the single-cycle core once instruction and data memory are unified.

---
 rtl/ctrl_pkg.sv | 66 ++++++
 rtl/multicycle_ctrl_if.sv | 39 +++
 rtl/alu_decoder.sv | 40 ++++
 rtl/multicycle_ctrl.sv | 147 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control sequencer.
// Imported by the decoder, the controller top and anything driving them.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        BEQ,
        JAL,
        ILLEGAL
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Loads, ALU-immediates and unknown opcodes all fall back to the I format.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction fields, memory handshake and datapath controls between the
// sequencer (master) and the datapath/memory side (slave).
interface multicycle_ctrl_if;

    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;
    logic        mem_ready;

    logic        mem_req;
    logic        mem_we;
    logic        adr_src;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic [1:0]  result_src;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  imm_src;
    logic [2:0]  alu_control;
    logic        halted;
    logic [31:0] instret;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
               result_src, alu_src_a, alu_src_b, imm_src, alu_control,
               halted, instret
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
               result_src, alu_src_a, alu_src_b, imm_src, alu_control,
               halted, instret
    );

endinterface

// File: rtl/alu_decoder.sv
// Maps the controller's ALUOp plus funct fields to an ALU operation, and
// flags funct3 values the R/I subset does not implement.
module alu_decoder
    import ctrl_pkg::*;
(
    input  aluop_t     alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control,
    output logic       funct_legal
);

    always_comb begin
        funct_legal = 1'b0;
        case (funct3)
            3'b000, 3'b010, 3'b110, 3'b111: funct_legal = 1'b1;
            default:                        funct_legal = 1'b0;
        endcase
    end

    // funct7b5 only selects sub for register-register ops; addi ignores it.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: walks the shared-ALU datapath through
// fetch/decode/execute/memory/writeback and counts retired instructions.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_ctrl_if.master      bus
);

    state_t      state;
    logic [31:0] instret_q;
    aluop_t      alu_op;
    logic        funct_legal;
    logic        retire;

    logic        mem_req_c, mem_we_c, adr_src_c, ir_write_c, pc_write_c, reg_write_c;
    logic        halted_c;
    logic [1:0]  result_src_c, src_a_c, src_b_c;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (bus.funct3),
        .funct7b5    (bus.funct7b5),
        .op5         (bus.op[5]),
        .alu_control (bus.alu_control),
        .funct_legal (funct_legal)
    );

    assign retire = (state == MEMWB) || (state == ALUWB) || (state == BEQ) ||
                    ((state == MEMWRITE) && bus.mem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            instret_q <= '0;
        end else begin
            if (retire)
                instret_q <= instret_q + 32'd1;
            case (state)
                FETCH:    if (bus.mem_ready) state <= DECODE;
                DECODE: begin
                    case (bus.op)
                        OP_LOAD, OP_STORE: state <= MEMADR;
                        OP_RTYPE:  state <= funct_legal ? EXECR : ILLEGAL;
                        OP_ITYPE:  state <= funct_legal ? EXECI : ILLEGAL;
                        OP_BRANCH: state <= (bus.funct3 == 3'b000) ? BEQ : ILLEGAL;
                        OP_JAL:    state <= JAL;
                        default:   state <= ILLEGAL;
                    endcase
                end
                MEMADR:   state <= bus.op[5] ? MEMWRITE : MEMREAD;
                MEMREAD:  if (bus.mem_ready) state <= MEMWB;
                MEMWB:    state <= FETCH;
                MEMWRITE: if (bus.mem_ready) state <= FETCH;
                EXECR:    state <= ALUWB;
                EXECI:    state <= ALUWB;
                ALUWB:    state <= FETCH;
                BEQ:      state <= FETCH;
                JAL:      state <= ALUWB;
                ILLEGAL:  state <= ILLEGAL;
                default:  state <= FETCH;
            endcase
        end
    end

    always_comb begin
        mem_req_c    = 1'b0;
        mem_we_c     = 1'b0;
        adr_src_c    = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        halted_c     = 1'b0;
        result_src_c = RES_ALUOUT;
        src_a_c      = SRCA_PC;
        src_b_c      = SRCB_RD2;
        alu_op       = ALUOP_ADD;
        case (state)
            FETCH: begin
                mem_req_c    = 1'b1;
                src_b_c      = SRCB_FOUR;
                result_src_c = RES_ALURESULT;
                ir_write_c   = bus.mem_ready;
                pc_write_c   = bus.mem_ready;
            end
            DECODE: begin
                src_a_c = SRCA_OLDPC;
                src_b_c = SRCB_IMM;
            end
            MEMADR: begin
                src_a_c = SRCA_RD1;
                src_b_c = SRCB_IMM;
            end
            MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
            end
            MEMWB: begin
                result_src_c = RES_DATA;
                reg_write_c  = 1'b1;
            end
            MEMWRITE: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                adr_src_c = 1'b1;
            end
            EXECR: begin
                src_a_c = SRCA_RD1;
                alu_op  = ALUOP_FUNCT;
            end
            EXECI: begin
                src_a_c = SRCA_RD1;
                src_b_c = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
            end
            ALUWB:   reg_write_c = 1'b1;
            BEQ: begin
                src_a_c    = SRCA_RD1;
                alu_op     = ALUOP_SUB;
                pc_write_c = bus.zero;
            end
            JAL: begin
                src_a_c    = SRCA_OLDPC;
                src_b_c    = SRCB_FOUR;
                pc_write_c = 1'b1;
            end
            ILLEGAL: halted_c = 1'b1;
            default: ;
        endcase
    end

    // Strobes are gated by rst_n so an aborted access cannot leak a write.
    assign bus.mem_req    = mem_req_c   & rst_n;
    assign bus.mem_we     = mem_we_c    & rst_n;
    assign bus.ir_write   = ir_write_c  & rst_n;
    assign bus.pc_write   = pc_write_c  & rst_n;
    assign bus.reg_write  = reg_write_c & rst_n;
    assign bus.adr_src    = adr_src_c;
    assign bus.result_src = result_src_c;
    assign bus.alu_src_a  = src_a_c;
    assign bus.alu_src_b  = src_b_c;
    assign bus.imm_src    = imm_src_of(bus.op);
    assign bus.halted     = halted_c;
    assign bus.instret    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl: each instruction is
// expanded into its expected per-cycle control outputs and retirements.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus();

    multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic [2:0] alu_control;
        logic       halted;
    } outs_t;

    typedef struct {
        outs_t o;
        bit    rdy;
        bit    ret;
    } step_t;

    typedef enum {K_LW, K_SW, K_R, K_I, K_BEQ, K_JAL, K_ILL} kind_t;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_instret = '0;

    function automatic outs_t observe();
        outs_t o;
        o.mem_req     = bus.mem_req;
        o.mem_we      = bus.mem_we;
        o.adr_src     = bus.adr_src;
        o.ir_write    = bus.ir_write;
        o.pc_write    = bus.pc_write;
        o.reg_write   = bus.reg_write;
        o.result_src  = bus.result_src;
        o.alu_src_a   = bus.alu_src_a;
        o.alu_src_b   = bus.alu_src_b;
        o.imm_src     = bus.imm_src;
        o.alu_control = bus.alu_control;
        o.halted      = bus.halted;
        return o;
    endfunction

    function automatic bit f3_ok(input logic [2:0] f3);
        return (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
    endfunction

    function automatic kind_t classify(input logic [6:0] o, input logic [2:0] f3);
        case (o)
            7'b0000011: return K_LW;
            7'b0100011: return K_SW;
            7'b0110011: return f3_ok(f3) ? K_R : K_ILL;
            7'b0010011: return f3_ok(f3) ? K_I : K_ILL;
            7'b1100011: return (f3 == 3'd0) ? K_BEQ : K_ILL;
            7'b1101111: return K_JAL;
            default:    return K_ILL;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return (o[5] && f7) ? 3'b001 : 3'b000;
            3'd2:    return 3'b101;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        case (o)
            7'b0100011: return 2'b01;
            7'b1100011: return 2'b10;
            7'b1101111: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    // Expands one instruction into its expected cycles and runs it from FETCH.
    task automatic test_instr(input string name, input logic [6:0] iop, input logic [2:0] if3,
                              input logic if7, input logic izero, input int fwait, input int dwait);
        step_t q[$];
        outs_t base, c, act;
        kind_t k;
        base = '0;
        base.imm_src = imm_of(iop);
        k = classify(iop, if3);

        c = base; c.mem_req = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10;
        repeat (fwait) q.push_back('{c, 1'b0, 1'b0});
        c.ir_write = 1'b1; c.pc_write = 1'b1;
        q.push_back('{c, 1'b1, 1'b0});
        c = base; c.alu_src_a = 2'b01; c.alu_src_b = 2'b01;
        q.push_back('{c, bit'($urandom_range(0, 1)), 1'b0});

        case (k)
            K_LW, K_SW: begin
                c = base; c.alu_src_a = 2'b10; c.alu_src_b = 2'b01;
                q.push_back('{c, bit'($urandom_range(0, 1)), 1'b0});
                c = base; c.mem_req = 1'b1; c.adr_src = 1'b1; c.mem_we = (k == K_SW);
                repeat (dwait) q.push_back('{c, 1'b0, 1'b0});
                q.push_back('{c, 1'b1, (k == K_SW)});
                if (k == K_LW) begin
                    c = base; c.result_src = 2'b01; c.reg_write = 1'b1;
                    q.push_back('{c, bit'($urandom_range(0, 1)), 1'b1});
                end
            end
            K_R, K_I: begin
                c = base; c.alu_src_a = 2'b10; c.alu_src_b = (k == K_I) ? 2'b01 : 2'b00;
                c.alu_control = alu_of(iop, if3, if7);
                q.push_back('{c, bit'($urandom_range(0, 1)), 1'b0});
                c = base; c.reg_write = 1'b1;
                q.push_back('{c, bit'($urandom_range(0, 1)), 1'b1});
            end
            K_BEQ: begin
                c = base; c.alu_src_a = 2'b10; c.alu_control = 3'b001; c.pc_write = izero;
                q.push_back('{c, bit'($urandom_range(0, 1)), 1'b1});
            end
            K_JAL: begin
                c = base; c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_write = 1'b1;
                q.push_back('{c, bit'($urandom_range(0, 1)), 1'b0});
                c = base; c.reg_write = 1'b1;
                q.push_back('{c, bit'($urandom_range(0, 1)), 1'b1});
            end
            default: begin
                c = base; c.halted = 1'b1;
                repeat (10) q.push_back('{c, bit'($urandom_range(0, 1)), 1'b0});
            end
        endcase

        bus.op = iop;
        bus.funct3 = if3;
        bus.funct7b5 = if7;
        bus.zero = izero;
        foreach (q[i]) begin
            @(negedge clk);
            bus.mem_ready = q[i].rdy;
            #1;
            act = observe();
            checks++;
            if (act !== q[i].o) begin
                failures++;
                $display("[TB] FAIL %s cycle %0d outputs: got %h expected %h", name, i, act, q[i].o);
            end
            @(posedge clk);
            #1;
            if (q[i].ret) exp_instret = exp_instret + 32'd1;
            checks++;
            if (bus.instret !== exp_instret) begin
                failures++;
                $display("[TB] FAIL %s cycle %0d instret: got %h expected %h", name, i, bus.instret, exp_instret);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) begin
            @(negedge clk);
            bus.mem_ready = bit'($urandom_range(0, 1));
            #1;
            checks++;
            if ({bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write, bus.reg_write} !== 5'b0 ||
                bus.instret !== 32'd0) begin
                failures++;
                $display("[TB] FAIL reset_hold strobes/instret: got %b/%h expected 00000/0",
                         {bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write, bus.reg_write}, bus.instret);
            end
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.halted !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_release req/we/halted: got %b%b%b expected 100",
                     bus.mem_req, bus.mem_we, bus.halted);
        end
        exp_instret = '0;
    endtask

    task automatic pulse_reset(input string name);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_instret = '0;
        checks++;
        if (bus.halted !== 1'b0 || bus.mem_req !== 1'b0 || bus.instret !== 32'd0) begin
            failures++;
            $display("[TB] FAIL %s in reset halted/req/instret: got %b/%b/%h expected 0/0/0",
                     name, bus.halted, bus.mem_req, bus.instret);
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.mem_req !== 1'b1 || bus.halted !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s release req/halted: got %b/%b expected 1/0", name, bus.mem_req, bus.halted);
        end
    endtask

    task automatic test_directed();
        test_instr("lw_nowait", 7'b0000011, 3'd2, 1'b0, 1'b0, 0, 0);
        test_instr("sw_2wait", 7'b0100011, 3'd2, 1'b0, 1'b0, 0, 2);
        test_instr("beq_taken", 7'b1100011, 3'd0, 1'b0, 1'b1, 1, 0);
        test_instr("beq_not_taken", 7'b1100011, 3'd0, 1'b0, 1'b0, 0, 0);
        test_instr("r_sub", 7'b0110011, 3'd0, 1'b1, 1'b0, 0, 0);
        test_instr("i_add_f7", 7'b0010011, 3'd0, 1'b1, 1'b0, 0, 0);
        test_instr("jal", 7'b1101111, 3'd0, 1'b0, 1'b0, 2, 0);
    endtask

    task automatic test_random();
        logic [6:0] ops [6];
        logic [2:0] legal [4];
        logic [6:0] o;
        logic [2:0] f3;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
        legal = '{3'd0, 3'd2, 3'd6, 3'd7};
        for (int n = 0; n < 40; n++) begin
            o = ops[$urandom_range(0, 5)];
            f3 = legal[$urandom_range(0, 3)];
            if (o == 7'b1100011) f3 = 3'd0;
            test_instr("random", o, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_illegal();
        test_instr("illegal_op", 7'b0000000, 3'd0, 1'b0, 1'b0, 0, 0);
        pulse_reset("illegal_op");
        test_instr("illegal_rfunct", 7'b0110011, 3'd1, 1'b0, 1'b0, 0, 0);
        pulse_reset("illegal_rfunct");
        test_instr("illegal_beqfunct", 7'b1100011, 3'd1, 1'b0, 1'b1, 0, 0);
        pulse_reset("illegal_beqfunct");
        test_instr("after_illegal", 7'b0010011, 3'd7, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_wrap();
        bus.mem_ready = 1'b0;
        force dut.instret_q = 32'hFFFF_FFFE;
        #1;
        release dut.instret_q;
        exp_instret = 32'hFFFF_FFFE;
        test_instr("wrap_r", 7'b0110011, 3'd6, 1'b0, 1'b0, 0, 0);
        test_instr("wrap_i", 7'b0010011, 3'd2, 1'b0, 1'b0, 1, 0);
        checks++;
        if (bus.instret !== 32'd0) begin
            failures++;
            $display("[TB] FAIL wrap instret: got %h expected 00000000", bus.instret);
        end
    endtask

    task automatic test_midop_reset();
        bus.op = 7'b0100011;
        bus.funct3 = 3'd2;
        @(negedge clk); bus.mem_ready = 1'b1;
        @(negedge clk); bus.mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midop_wait req/we: got %b%b expected 11", bus.mem_req, bus.mem_we);
        end
        rst_n = 1'b0;
        #1;
        exp_instret = '0;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.instret !== 32'd0) begin
            failures++;
            $display("[TB] FAIL midop_reset req/we/instret: got %b%b/%h expected 00/0",
                     bus.mem_req, bus.mem_we, bus.instret);
        end
        repeat (2) begin
            @(negedge clk);
            bus.mem_ready = 1'b1;
            #1;
            checks++;
            if ({bus.mem_req, bus.mem_we, bus.reg_write, bus.pc_write} !== 4'b0) begin
                failures++;
                $display("[TB] FAIL midop_hold strobes: got %b expected 0000",
                         {bus.mem_req, bus.mem_we, bus.reg_write, bus.pc_write});
            end
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        rst_n = 1'b1;
        test_instr("after_midop", 7'b0000011, 3'd2, 1'b0, 1'b0, 0, 1);
    endtask

    initial begin
        bus.op = 7'b0000000;
        bus.funct3 = 3'd0;
        bus.funct7b5 = 1'b0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_wrap();
        test_midop_reset();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
